// File: rtl/systolic_obuf_responder_pkg.sv
// ----------------------------------------------------------------------------
// obuf_pkg
// Shared definitions for the systolic output-buffer responder:
//   calc_out_width : row width derivation (ARRAY_M * ACC_WIDTH)
//   drain_state_e  : drain FSM state encoding
//   addr_in_range  : true when no address bit at or above depth_log2 is set
// No ports (package).
// ----------------------------------------------------------------------------
package obuf_pkg;

   function automatic int calc_out_width(input int array_m, input int acc_width);
      return array_m * acc_width;
   endfunction

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HOLD  = 2'd2,
      ST_DONE  = 2'd3
   } drain_state_e;

   // Callers zero-extend the request address to 64 bits.
   function automatic logic addr_in_range(input logic [63:0] addr, input int depth_log2);
      return (addr >> depth_log2) == 64'd0;
   endfunction

endpackage

// File: rtl/systolic_obuf_responder_if.sv
// ----------------------------------------------------------------------------
// systolic_obuf_responder_if
// Bundles the array-side obuf request/response signals and the host-side
// drain stream.
//   master : array + host side (drives requests, drain_start, drain_ready)
//   slave  : responder side (drives read data, drain stream, status)
//
// Drain handshake: a row transfers on every rising edge where drain_valid and
// drain_ready are both high. Once drain_valid rises it stays high, with
// drain_data/drain_addr unchanged, until that transfer; drain_valid never
// depends combinationally on drain_ready.
// ----------------------------------------------------------------------------
interface systolic_obuf_responder_if
   import obuf_pkg::*;
#(
   parameter int ARRAY_M         = 4,
   parameter int ACC_WIDTH       = 48,
   parameter int OBUF_ADDR_WIDTH = 16,
   parameter int OBUF_DEPTH_LOG2 = 8
);
   localparam int OUT_WIDTH = calc_out_width(ARRAY_M, ACC_WIDTH);

   logic                       sys_obuf_write_req;
   logic [OBUF_ADDR_WIDTH-1:0] sys_obuf_write_addr;
   logic [OUT_WIDTH-1:0]       obuf_write_data;
   logic                       sys_obuf_read_req;
   logic [OBUF_ADDR_WIDTH-1:0] sys_obuf_read_addr;
   logic [OUT_WIDTH-1:0]       obuf_read_data;
   logic                       obuf_read_valid;

   logic                       drain_start;
   logic [OBUF_DEPTH_LOG2-1:0] drain_base;
   logic [OBUF_DEPTH_LOG2:0]   drain_count;
   logic                       drain_valid;
   logic                       drain_ready;
   logic [OUT_WIDTH-1:0]       drain_data;
   logic [OBUF_DEPTH_LOG2-1:0] drain_addr;
   logic                       drain_busy;
   logic                       drain_done;
   logic                       err_oob;

   modport master (
      output sys_obuf_write_req, sys_obuf_write_addr, obuf_write_data,
      output sys_obuf_read_req, sys_obuf_read_addr,
      input  obuf_read_data, obuf_read_valid,
      output drain_start, drain_base, drain_count, drain_ready,
      input  drain_valid, drain_data, drain_addr, drain_busy, drain_done,
      input  err_oob
   );

   modport slave (
      input  sys_obuf_write_req, sys_obuf_write_addr, obuf_write_data,
      input  sys_obuf_read_req, sys_obuf_read_addr,
      output obuf_read_data, obuf_read_valid,
      input  drain_start, drain_base, drain_count, drain_ready,
      output drain_valid, drain_data, drain_addr, drain_busy, drain_done,
      output err_oob
   );

endinterface

// File: rtl/systolic_obuf_responder_ram.sv
// ----------------------------------------------------------------------------
// obuf_ram
// 1W1R storage, 2**ADDR_WIDTH rows x DATA_WIDTH. Synchronous read with
// write-first bypass: a read and write to the same row in one cycle returns
// the new write data. Array contents are never reset; only the read register
// is.
// Ports:
//   clk, reset   : clock, async active-low reset (read register only)
//   wr_en/addr/data : write port
//   rd_en/addr   : read request; rd_data updates on the next edge
//   rd_data      : registered read data, held while rd_en is low
// ----------------------------------------------------------------------------
module obuf_ram #(
   parameter int DATA_WIDTH = 192,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);
   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
      end
   end

endmodule

// File: rtl/systolic_obuf_responder.sv
// ----------------------------------------------------------------------------
// systolic_obuf_responder
// Far-side model of the systolic array's output buffer. Accepts accumulator
// row writes, answers partial-sum reads one cycle later (write-first), flags
// out-of-range requests, and drains a wrapped address range to the host over
// a valid/ready stream.
// Ports:
//   clk         : clock, rising edge
//   reset       : asynchronous, active-low
//   bus         : obuf request/response and drain stream (slave modport)
//   drain_state : current drain FSM state, for observation
// err_oob is registered: it pulses in the cycle after the offending request,
// aligned with the read response of an out-of-range read.
// ----------------------------------------------------------------------------
module systolic_obuf_responder
   import obuf_pkg::*;
#(
   parameter int ARRAY_M         = 4,
   parameter int ACC_WIDTH       = 48,
   parameter int OBUF_ADDR_WIDTH = 16,
   parameter int OBUF_DEPTH_LOG2 = 8
) (
   input  logic                            clk,
   input  logic                            reset,
   systolic_obuf_responder_if.slave        bus,
   output drain_state_e                    drain_state
);
   localparam int OUT_WIDTH = calc_out_width(ARRAY_M, ACC_WIDTH);
   localparam int CNT_WIDTH = OBUF_DEPTH_LOG2 + 1;

   logic                       wr_in_range;
   logic                       rd_in_range;
   logic                       ram_wr_en;
   logic                       ram_rd_en;
   logic [OBUF_DEPTH_LOG2-1:0] ram_rd_addr;
   logic [OUT_WIDTH-1:0]       ram_rd_data;

   drain_state_e               state_q;
   drain_state_e               state_d;
   logic                       fetch_grant;
   logic                       drain_ack;
   logic                       last_row;
   logic                       drain_valid_c;
   logic                       drain_done_c;

   logic [OBUF_DEPTH_LOG2-1:0] addr_q;
   logic [CNT_WIDTH-1:0]       remain_q;
   logic                       fetch_q;
   logic [OUT_WIDTH-1:0]       drain_data_q;
   logic                       rd_valid_q;
   logic                       rd_zero_q;
   logic                       err_q;

   // ---------------- request decode ----------------
   assign wr_in_range = addr_in_range(64'(bus.sys_obuf_write_addr), OBUF_DEPTH_LOG2);
   assign rd_in_range = addr_in_range(64'(bus.sys_obuf_read_addr), OBUF_DEPTH_LOG2);

   assign ram_wr_en = bus.sys_obuf_write_req && wr_in_range;

   // Sys reads own the read port whenever requested (even out of range, so
   // the drain fetch timing only depends on the request strobe).
   assign ram_rd_en   = (bus.sys_obuf_read_req && rd_in_range) || fetch_grant;
   assign ram_rd_addr = bus.sys_obuf_read_req ?
                        bus.sys_obuf_read_addr[OBUF_DEPTH_LOG2-1:0] : addr_q;

   obuf_ram #(
      .DATA_WIDTH (OUT_WIDTH),
      .ADDR_WIDTH (OBUF_DEPTH_LOG2)
   ) u_ram (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (ram_wr_en),
      .wr_addr (bus.sys_obuf_write_addr[OBUF_DEPTH_LOG2-1:0]),
      .wr_data (bus.obuf_write_data),
      .rd_en   (ram_rd_en),
      .rd_addr (ram_rd_addr),
      .rd_data (ram_rd_data)
   );

   // ---------------- drain FSM ----------------
   assign last_row = (remain_q == CNT_WIDTH'(1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      fetch_grant   = 1'b0;
      drain_ack     = 1'b0;
      drain_valid_c = 1'b0;
      drain_done_c  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.drain_start) begin
               state_d = (bus.drain_count == '0) ? ST_DONE : ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (!bus.sys_obuf_read_req) begin
               fetch_grant = 1'b1;
               state_d     = ST_HOLD;
            end
         end
         ST_HOLD: begin
            drain_valid_c = 1'b1;
            if (bus.drain_ready) begin
               drain_ack = 1'b1;
               state_d   = last_row ? ST_DONE : ST_FETCH;
            end
         end
         ST_DONE: begin
            drain_done_c = 1'b1;
            state_d      = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr_q       <= '0;
         remain_q     <= '0;
         fetch_q      <= 1'b0;
         drain_data_q <= '0;
         rd_valid_q   <= 1'b0;
         rd_zero_q    <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         if ((state_q == ST_IDLE) && bus.drain_start) begin
            addr_q   <= bus.drain_base;
            remain_q <= bus.drain_count;
         end else if (drain_ack && !last_row) begin
            // Row index wraps naturally at the top of the array.
            addr_q   <= addr_q + OBUF_DEPTH_LOG2'(1);
            remain_q <= remain_q - CNT_WIDTH'(1);
         end

         // The fetched row appears on ram_rd_data in the first HOLD cycle;
         // snapshot it then so later sys reads cannot disturb the held row.
         fetch_q <= fetch_grant;
         if (fetch_q) begin
            drain_data_q <= ram_rd_data;
         end

         rd_valid_q <= bus.sys_obuf_read_req;
         rd_zero_q  <= bus.sys_obuf_read_req && !rd_in_range;
         err_q      <= (bus.sys_obuf_write_req && !wr_in_range) ||
                       (bus.sys_obuf_read_req && !rd_in_range);
      end
   end

   // ---------------- outputs ----------------
   assign bus.obuf_read_data  = rd_zero_q ? '0 : ram_rd_data;
   assign bus.obuf_read_valid = rd_valid_q;
   assign bus.err_oob         = err_q;

   assign bus.drain_valid = drain_valid_c;
   assign bus.drain_data  = fetch_q ? ram_rd_data : drain_data_q;
   assign bus.drain_addr  = addr_q;
   assign bus.drain_busy  = (state_q != ST_IDLE);
   assign bus.drain_done  = drain_done_c;
   assign drain_state     = state_q;

endmodule

// File: tb/tb_systolic_obuf_responder.sv
module tb_systolic_obuf_responder;
   import obuf_pkg::*;

   localparam int W = 192;

   logic         clk;
   logic         reset;
   drain_state_e dbg_state;

   int n_checks;
   int n_errors;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] exp_addr_q[$];

   systolic_obuf_responder_if bus ();

   systolic_obuf_responder dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus),
      .drain_state (dbg_state)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- checker ----------------
   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- drivers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sys_write(input logic [15:0] addr, input logic [W-1:0] data);
      bus.sys_obuf_write_req  = 1'b1;
      bus.sys_obuf_write_addr = addr;
      bus.obuf_write_data     = data;
      step();
      bus.sys_obuf_write_req  = 1'b0;
   endtask

   task automatic sys_read_check(input string tag, input logic [15:0] addr, input logic [W-1:0] exp);
      bus.sys_obuf_read_req  = 1'b1;
      bus.sys_obuf_read_addr = addr;
      step();
      bus.sys_obuf_read_req  = 1'b0;
      check({tag, "_valid"}, W'(bus.obuf_read_valid), W'(1));
      check({tag, "_data"}, bus.obuf_read_data, exp);
   endtask

   task automatic start_drain(input logic [7:0] base, input logic [8:0] count);
      bus.drain_start = 1'b1;
      bus.drain_base  = base;
      bus.drain_count = count;
      step();
      bus.drain_start = 1'b0;
   endtask

   task automatic check_reset_values(input string pfx);
      check({pfx, "_rd_data"}, bus.obuf_read_data, W'(0));
      check({pfx, "_rd_valid"}, W'(bus.obuf_read_valid), W'(0));
      check({pfx, "_dvalid"}, W'(bus.drain_valid), W'(0));
      check({pfx, "_ddata"}, bus.drain_data, W'(0));
      check({pfx, "_daddr"}, W'(bus.drain_addr), W'(0));
      check({pfx, "_busy"}, W'(bus.drain_busy), W'(0));
      check({pfx, "_done"}, W'(bus.drain_done), W'(0));
      check({pfx, "_err"}, W'(bus.err_oob), W'(0));
      check({pfx, "_state"}, W'(dbg_state), W'(ST_IDLE));
   endtask

   // Consumes a drain already started; compares every handshake against the
   // expected queues and counts drain_done pulses.
   task automatic drain_collect(input string tag, input int budget, input bit toggle_ready,
                                input int sysrd_cycles, input int mid_start_cyc);
      int done_cnt;
      int cyc;
      done_cnt = 0;
      cyc = 0;
      while (done_cnt == 0 && cyc < budget) begin
         bus.drain_ready       = toggle_ready ? ((cyc % 2) == 0) : 1'b1;
         bus.sys_obuf_read_req = (cyc < sysrd_cycles);
         bus.sys_obuf_read_addr = 16'd254;
         bus.drain_start = (cyc == mid_start_cyc);
         bus.drain_base  = 8'd0;
         bus.drain_count = 9'd1;
         if (cyc < sysrd_cycles) begin
            check({tag, "_stall_state"}, W'(dbg_state), W'(ST_FETCH));
            check({tag, "_stall_valid"}, W'(bus.drain_valid), W'(0));
         end
         if (bus.drain_valid && bus.drain_ready) begin
            if (exp_q.size() == 0) begin
               check({tag, "_extra_row"}, W'(1), W'(0));
            end else begin
               check({tag, "_addr"}, W'(bus.drain_addr), exp_addr_q.pop_front());
               check({tag, "_data"}, bus.drain_data, exp_q.pop_front());
            end
         end
         step();
         if (cyc < sysrd_cycles) begin
            check({tag, "_sysrd_data"}, bus.obuf_read_data, W'(1));
         end
         if (bus.drain_done) done_cnt++;
         cyc++;
      end
      bus.drain_start       = 1'b0;
      bus.sys_obuf_read_req = 1'b0;
      bus.drain_ready       = 1'b0;
      check({tag, "_timeout"}, W'(cyc < budget), W'(1));
      step();
      if (bus.drain_done) done_cnt++;
      step();
      if (bus.drain_done) done_cnt++;
      check({tag, "_done_count"}, W'(done_cnt), W'(1));
      check({tag, "_rows_left"}, W'(exp_q.size()), W'(0));
      check({tag, "_busy_after"}, W'(bus.drain_busy), W'(0));
      exp_q.delete();
      exp_addr_q.delete();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [W-1:0] v5;
      logic [W-1:0] va;
      logic [W-1:0] vb;
      logic [W-1:0] z0;
      logic [W-1:0] z1;
      int i;
      v5 = {4{48'h0000_4321_1234}};
      va = {4{48'hAAAA_0000_5555}};
      vb = {4{48'hBBBB_1111_2222}};
      z0 = {4{48'h0123_4567_89AB}};
      z1 = {4{48'hFEDC_BA98_7654}};
      n_checks = 0;
      n_errors = 0;

      reset = 1'b0;
      bus.sys_obuf_write_req  = 1'b0;
      bus.sys_obuf_write_addr = '0;
      bus.obuf_write_data     = '0;
      bus.sys_obuf_read_req   = 1'b0;
      bus.sys_obuf_read_addr  = '0;
      bus.drain_start = 1'b0;
      bus.drain_base  = '0;
      bus.drain_count = '0;
      bus.drain_ready = 1'b0;
      step();
      step();
      check_reset_values("reset");
      reset = 1'b1;
      step();

      // Write then read row 5; valid lasts exactly one cycle.
      sys_write(16'd5, v5);
      sys_read_check("rd5", 16'd5, v5);
      step();
      check("rd5_valid_drop", W'(bus.obuf_read_valid), W'(0));

      // Same-cycle write/read of row 9 returns the new data.
      sys_write(16'd9, vb);
      bus.sys_obuf_write_req  = 1'b1;
      bus.sys_obuf_write_addr = 16'd9;
      bus.obuf_write_data     = va;
      sys_read_check("fwd9", 16'd9, va);
      bus.sys_obuf_write_req  = 1'b0;
      sys_read_check("rd9_after", 16'd9, va);

      // Out-of-range write is dropped; out-of-range read returns zero.
      sys_write(16'd0, vb);
      sys_write(16'h0100, va);
      check("oob_wr_err", W'(bus.err_oob), W'(1));
      step();
      check("oob_wr_err_drop", W'(bus.err_oob), W'(0));
      sys_read_check("row0_kept", 16'd0, vb);
      check("inrange_rd_err", W'(bus.err_oob), W'(0));
      sys_read_check("oob_rd", 16'h0100, W'(0));
      check("oob_rd_err", W'(bus.err_oob), W'(1));
      step();

      // Wrapped drain 254,255,0,1 with ready toggling.
      sys_write(16'd254, W'(1));
      sys_write(16'd255, W'(2));
      sys_write(16'd0, W'(3));
      sys_write(16'd1, W'(4));
      for (i = 0; i < 4; i++) begin
         exp_q.push_back(W'(i + 1));
         exp_addr_q.push_back(W'((254 + i) % 256));
      end
      start_drain(8'd254, 9'd4);
      check("drain1_busy", W'(bus.drain_busy), W'(1));
      drain_collect("drain1", 40, 1'b1, 0, -1);

      // Drain of 3 rows stalled by 5 sys reads, with an ignored restart.
      sys_write(16'd20, W'(192'hA0));
      sys_write(16'd21, W'(192'hA1));
      sys_write(16'd22, W'(192'hA2));
      for (i = 0; i < 3; i++) begin
         exp_q.push_back(W'(192'hA0 + i));
         exp_addr_q.push_back(W'(20 + i));
      end
      start_drain(8'd20, 9'd3);
      drain_collect("drain2", 40, 1'b0, 5, 2);

      // Zero-length drain: done one cycle after start.
      start_drain(8'd7, 9'd0);
      check("cnt0_done", W'(bus.drain_done), W'(1));
      check("cnt0_state", W'(dbg_state), W'(ST_DONE));
      step();
      check("cnt0_done_drop", W'(bus.drain_done), W'(0));
      check("cnt0_busy", W'(bus.drain_busy), W'(0));

      // Hold snapshot, then reset in HOLD.
      sys_write(16'd40, z0);
      start_drain(8'd40, 9'd2);
      for (i = 0; i < 10 && !bus.drain_valid; i++) step();
      check("hold_reached", W'(bus.drain_valid), W'(1));
      check("hold_data", bus.drain_data, z0);
      sys_write(16'd40, z1);
      check("hold_snapshot", bus.drain_data, z0);
      check("hold_addr", W'(bus.drain_addr), W'(40));
      check("hold_valid", W'(bus.drain_valid), W'(1));
      reset = 1'b0;
      #1;
      check_reset_values("midreset");
      step();
      check("midreset_done1", W'(bus.drain_done), W'(0));
      step();
      check("midreset_done2", W'(bus.drain_done), W'(0));
      reset = 1'b1;
      step();
      check("post_reset_done", W'(bus.drain_done), W'(0));
      sys_read_check("retained40", 16'd40, z1);
      sys_read_check("retained5", 16'd5, v5);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Absolute time bound in case something stalls outside the bounded loops.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/systolic_obuf_responder.md
# systolic_obuf_responder

Output-buffer responder on the far side of the systolic array's obuf interface. It accepts the array's accumulator write requests, serves its partial-sum read requests with fixed one-cycle latency and write-first forwarding, and streams a selected address range out to the host over a valid/ready drain port. It replaces the open-loop obuf stimulus used around `systolic_array` with a stateful storage model that is also synthesizable.

## Interface
- `ARRAY_M`, 4, PE columns; words per obuf row.
- `ACC_WIDTH`, 48, accumulator width per column.
- `OBUF_ADDR_WIDTH`, 16, request address width.
- `OBUF_DEPTH_LOG2`, 8, implemented rows (`2**OBUF_DEPTH_LOG2`).
- `OUT_WIDTH`, `ARRAY_M*ACC_WIDTH`, row width (derived; not overridable).
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `sys_obuf_write_req` in 1: array write strobe.
- `sys_obuf_write_addr` in `OBUF_ADDR_WIDTH`: write row address.
- `obuf_write_data` in `OUT_WIDTH`: write row data.
- `sys_obuf_read_req` in 1: array read strobe.
- `sys_obuf_read_addr` in `OBUF_ADDR_WIDTH`: read row address.
- `obuf_read_data` out `OUT_WIDTH`: read data, registered.
- `obuf_read_valid` out 1: high for one cycle, one cycle after an accepted read.
- `drain_start` in 1: one-cycle pulse; honoured only in IDLE.
- `drain_base` in `OBUF_DEPTH_LOG2`: first drained row.
- `drain_count` in `OBUF_DEPTH_LOG2+1`: number of rows to drain.
- `drain_valid` out 1, `drain_ready` in 1: drain handshake.
- `drain_data` out `OUT_WIDTH`, `drain_addr` out `OBUF_DEPTH_LOG2`: current drained row and its index.
- `drain_busy` out 1: FSM is not IDLE.
- `drain_done` out 1: one-cycle pulse at the end of a drain.
- `err_oob` out 1: one-cycle pulse when a sys request address has any bit at or above `OBUF_DEPTH_LOG2` set.

## Operation
- Storage: 1W1R array of `2**OBUF_DEPTH_LOG2` x `OUT_WIDTH`. Contents are not reset.
- Write: on `sys_obuf_write_req`, if the address is in range, the row is written at the clock edge. If it is out of range, the write is dropped and `err_oob` pulses.
- Sys read: on `sys_obuf_read_req`, the next cycle presents the row with `obuf_read_valid`=1. An out-of-range read returns all zeros with valid=1 and pulses `err_oob`.
- Read/write collision: when a read and a write target the same row in the same cycle, the read returns the new write data (write-first).
- Read port arbitration: sys read has priority. The drain FSM fetches only in cycles with no sys read.
- Drain FSM:
  - IDLE: on `drain_start`, latch base and count. Count 0 -> DONE; otherwise -> FETCH.
  - FETCH: issue a read of `(base+i) mod depth`. If the port is granted -> HOLD; if it is blocked by a sys read, stay in FETCH.
  - HOLD: `drain_valid`=1, with `drain_data`/`drain_addr` stable. On `drain_ready`: if this is the last row -> DONE, else i++ and -> FETCH.
  - DONE: `drain_done`=1 for one cycle -> IDLE.
- HOLD snapshot: `drain_data` is the value captured at fetch. A later write to that row does not change the row being held.
- `drain_start` outside IDLE is ignored. Address wrap past the top row goes to row 0.
- Reset values: `obuf_read_data`=0, `obuf_read_valid`=0, `drain_valid`=0, `drain_data`=0, `drain_addr`=0, `drain_busy`=0, `drain_done`=0, `err_oob`=0, FSM=IDLE.
- Reset mid-drain: the FSM returns to IDLE immediately and no `drain_done` pulse is produced. Memory contents are retained.

## Timing
- Sys read latency: exactly 1 cycle. A new read can be accepted every cycle.
- Write-to-read: a write at edge N is visible to a read issued in cycle N (forwarded) and in every later cycle.
- Drain throughput: at most one row per 2 cycles. Each FETCH cycle blocked by a sys read adds one cycle.
- `drain_done` asserts in the cycle after the final HOLD handshake.
- With `drain_count`=0, `drain_done` asserts 1 cycle after `drain_start`.
- `drain_valid` stays high without a combinational dependence on `drain_ready`. Data is stable while valid is high and ready is low.

## Structure
- Package `obuf_pkg` holds:
  - the `OUT_WIDTH` derivation;
  - the drain state enum (IDLE, FETCH, HOLD, DONE);
  - the address range-check function.
- Sub-module `obuf_ram`: parameterized 1W1R memory with synchronous read and write-first bypass. The top level holds arbitration, error logic and the drain FSM.

## Test plan
- Write row 5 = `{4{48'h0000_4321_1234}}`, then read row 5 -> `obuf_read_data` equals that value one cycle later, with valid=1 for exactly one cycle.
- In one cycle, write row 9 = A while reading row 9 (previously B) -> read returns A.
- Write address `16'h0100` with depth 256 -> `err_oob` pulses and row 0 is unchanged. Read `16'h0100` -> data 0, valid=1, `err_oob` pulses.
- Fill rows 254, 255, 0, 1 with 1..4, then drain with base=254, count=4, `drain_ready` toggling 1,0,1,... -> `drain_addr` sequence 254,255,0,1 with data 1..4. `drain_done` fires once.
- Drain count=3 with a sys read every cycle for 5 cycles -> FETCH stalls during those 5 cycles, then completes with correct data. `drain_start` asserted mid-drain is ignored.
- Reset low during HOLD -> all outputs at reset values with no `drain_done`. After reset, a read of a previously written row returns its stored value.
